// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and widths for the APB round-robin arbiter.
// State encoding matches the compute master so debug views line up.
package apb_rr_arbiter_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after ptr_i wins,
// wrapping modulo N.
module apb_rr_arbiter_rr_pick
    import apb_rr_arbiter_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_req_o
);

    logic          found;
    logic [PW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = PW'((32'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/apb_rr_arbiter.sv
// Shares one APB slave between N_MASTERS masters with round-robin arbitration;
// the winner's command is registered and replayed as SETUP then ACCESS.
module apb_rr_arbiter
    import apb_rr_arbiter_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                             pclk_i,
    input  logic                             presetn_i,
    input  logic [N_MASTERS-1:0]             m_psel_i,
    input  logic [N_MASTERS-1:0]             m_penable_i,
    input  logic [N_MASTERS-1:0]             m_pwrite_i,
    input  logic [APB_ADDR_W*N_MASTERS-1:0]  m_paddr_i,
    input  logic [APB_DATA_W*N_MASTERS-1:0]  m_pwdata_i,
    output logic [APB_DATA_W-1:0]            m_prdata_o,
    output logic [N_MASTERS-1:0]             m_pready_o,
    output logic [N_MASTERS-1:0]             m_pslverr_o,
    output logic                             psel_o,
    output logic                             penable_o,
    output logic                             pwrite_o,
    output logic [APB_ADDR_W-1:0]            paddr_o,
    output logic [APB_DATA_W-1:0]            pwdata_o,
    input  logic [APB_DATA_W-1:0]            prdata_i,
    input  logic                             pready_i,
    input  logic                             pslverr_i,
    output logic [N_MASTERS-1:0]             grant_o,
    output logic                             busy_o
);

    localparam int unsigned PW = $clog2(N_MASTERS);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        gidx_q, gidx_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    apb_cmd_t             cmd_q, cmd_d;

    logic [N_MASTERS-1:0] pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 timeout_hit;

    // Requests are psel-only; penable from the masters carries no information here.
    logic unused_penable;
    assign unused_penable = ^m_penable_i;

    apb_rr_arbiter_rr_pick #(.N(N_MASTERS)) u_rr_pick (
        .req_i     (m_psel_i),
        .ptr_i     (ptr_q),
        .gnt_o     (pick_gnt),
        .idx_o     (pick_idx),
        .any_req_o (pick_any)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q <= IDLE;
            ptr_q   <= PW'(N_MASTERS - 1);
            gidx_q  <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        pwrite_o    = 1'b0;
        paddr_o     = '0;
        pwdata_o    = '0;
        busy_o      = 1'b0;
        grant_o     = '0;
        m_pready_o  = '0;
        m_pslverr_o = '0;
        m_prdata_o  = '0;

        // Slave-side command is held from the registers for the whole transfer.
        if (state_q == SETUP || state_q == ACCESS) begin
            psel_o   = 1'b1;
            busy_o   = 1'b1;
            grant_o  = gnt_q;
            pwrite_o = cmd_q.write;
            paddr_o  = cmd_q.addr;
            pwdata_o = cmd_q.wdata;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = SETUP;
                    ptr_d       = pick_idx;
                    gidx_d      = pick_idx;
                    gnt_d       = pick_gnt;
                    cnt_d       = '0;
                    cmd_d.write = m_pwrite_i[pick_idx];
                    cmd_d.addr  = m_paddr_i[pick_idx*APB_ADDR_W +: APB_ADDR_W];
                    cmd_d.wdata = m_pwdata_i[pick_idx*APB_DATA_W +: APB_DATA_W];
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                penable_o = 1'b1;
                // A withdrawn master gets no response; the slave cycle still finishes.
                if (pready_i) begin
                    state_d = IDLE;
                    if (m_psel_i[gidx_q]) begin
                        m_pready_o[gidx_q]  = 1'b1;
                        m_pslverr_o[gidx_q] = pslverr_i;
                        m_prdata_o          = prdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    if (m_psel_i[gidx_q]) begin
                        m_pready_o[gidx_q]  = 1'b1;
                        m_pslverr_o[gidx_q] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: directed master/slave scenarios with
// expected grants and responses queued ahead and checked by monitors.
module tb_apb_rr_arbiter;

    localparam int unsigned N = 2;

    logic            pclk = 1'b0;
    logic            presetn;
    logic [N-1:0]    m_psel, m_penable, m_pwrite;
    logic [8*N-1:0]  m_paddr;
    logic [32*N-1:0] m_pwdata;
    logic [31:0]     m_prdata_o;
    logic [N-1:0]    m_pready_o, m_pslverr_o;
    logic            psel_o, penable_o, pwrite_o;
    logic [7:0]      paddr_o;
    logic [31:0]     pwdata_o;
    logic [31:0]     prdata_i;
    logic            pready_i, pslverr_i;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    apb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT(4)) dut (
        .pclk_i      (pclk),
        .presetn_i   (presetn),
        .m_psel_i    (m_psel),
        .m_penable_i (m_penable),
        .m_pwrite_i  (m_pwrite),
        .m_paddr_i   (m_paddr),
        .m_pwdata_i  (m_pwdata),
        .m_prdata_o  (m_prdata_o),
        .m_pready_o  (m_pready_o),
        .m_pslverr_o (m_pslverr_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          k;
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t         rsp_q[$];
    logic [N-1:0] gnt_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_setup = -1;
    bit gap_on = 1'b0;
    int wait_n = 0;
    bit slv_hang = 1'b0;
    int acc = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: pready after wait_n wait states unless hung.
    initial forever begin
        @(posedge pclk);
        #1;
        if (psel_o && penable_o) begin
            pready_i = !slv_hang && (acc == wait_n);
            acc++;
        end else begin
            pready_i = 1'b0;
            acc = 0;
        end
    end

    // Response monitor.
    initial forever begin
        @(negedge pclk);
        if (presetn && m_pready_o != '0) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(m_pready_o), 64'(0));
            end else begin
                rsp_t e;
                logic [N-1:0] oh;
                e = rsp_q.pop_front();
                oh = '0;
                oh[e.k] = 1'b1;
                chk("rsp_pready", 64'(m_pready_o), 64'(oh));
                chk("rsp_pslverr", 64'(m_pslverr_o), 64'(e.err ? oh : '0));
                chk("rsp_prdata", 64'(m_prdata_o), 64'(e.rdata));
            end
        end
    end

    // Grant monitor, sampled in each SETUP cycle.
    initial forever begin
        @(negedge pclk);
        if (psel_o && !penable_o) begin
            if (gnt_q.size() == 0) begin
                chk("unexpected_grant", 64'(grant_o), 64'(0));
            end else begin
                chk("grant", 64'(grant_o), 64'(gnt_q.pop_front()));
            end
            if (gap_on && last_setup >= 0) chk("b2b_gap", 64'(cyc - last_setup), 64'(3));
            last_setup = cyc;
        end
    end

    task automatic mxfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        m_psel[k] = 1'b1;
        m_penable[k] = 1'b0;
        m_pwrite[k] = wr;
        m_paddr[8*k +: 8] = a;
        m_pwdata[32*k +: 32] = d;
        while (n < 40) begin
            @(negedge pclk);
            m_penable[k] = 1'b1;
            if (m_pready_o[k]) break;
            n++;
        end
        chk("xfer_done", 64'(n < 40), 64'(1));
        @(posedge pclk);
        #1;
        m_psel[k] = 1'b0;
        m_penable[k] = 1'b0;
    endtask

    task automatic wait_setup(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 20 && !ok) begin
            @(negedge pclk);
            ok = psel_o && !penable_o;
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int accs, rdy_at;
        presetn = 1'b0;
        m_psel = '0; m_penable = '0; m_pwrite = '0; m_paddr = '0; m_pwdata = '0;
        prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_ctrl", 64'({psel_o, penable_o, pwrite_o, busy_o}), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_bus", {24'(0), paddr_o, pwdata_o}, 64'(0));
        chk("rst_mresp", {m_pready_o, m_pslverr_o, m_prdata_o}, 64'(0));
        @(posedge pclk);
        #1 presetn = 1'b1;

        // Contention out of reset: m0 first, then m1.
        prdata_i = 32'h1111_0000; wait_n = 0;
        gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
        rsp_q.push_back('{0, 1'b0, 32'h1111_0000});
        rsp_q.push_back('{1, 1'b0, 32'h1111_0000});
        fork
            mxfer(0, 1'b0, 8'h10, 32'h0);
            mxfer(1, 1'b0, 8'h14, 32'h0);
        join

        // Fairness: continuous requests alternate with one IDLE between transfers.
        prdata_i = 32'h2222_0000; gap_on = 1'b1; last_setup = -1;
        for (int i = 0; i < 3; i++) begin
            gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
            rsp_q.push_back('{0, 1'b0, 32'h2222_0000});
            rsp_q.push_back('{1, 1'b0, 32'h2222_0000});
        end
        fork
            begin for (int i = 0; i < 3; i++) mxfer(0, 1'b0, 8'h18, 32'h0); end
            begin for (int i = 0; i < 3; i++) mxfer(1, 1'b0, 8'h1C, 32'h0); end
        join
        gap_on = 1'b0;

        // Single master, zero wait states: t+1 SETUP, t+2 ACCESS with completion.
        prdata_i = 32'hDEAD_BEEF;
        gnt_q.push_back(2'b01);
        rsp_q.push_back('{0, 1'b0, 32'hDEAD_BEEF});
        fork
            mxfer(0, 1'b0, 8'h04, 32'h0);
            begin
                @(negedge pclk);
                chk("lat_t0_psel", 64'(psel_o), 64'(0));
                @(negedge pclk);
                chk("lat_t1_ctrl", 64'({psel_o, penable_o}), 64'(2'b10));
                chk("lat_t1_paddr", 64'(paddr_o), 64'(8'h04));
                @(negedge pclk);
                chk("lat_t2_ctrl", 64'({psel_o, penable_o}), 64'(2'b11));
                chk("lat_t2_pready", 64'(m_pready_o), 64'(2'b01));
            end
        join

        // Write with 3 wait states; master inputs change but the shared port holds.
        wait_n = 3; prdata_i = 32'hA5A5_A5A5;
        gnt_q.push_back(2'b10);
        rsp_q.push_back('{1, 1'b0, 32'hA5A5_A5A5});
        fork
            mxfer(1, 1'b1, 8'h20, 32'h1234_5678);
            begin
                accs = 0; rdy_at = 0;
                wait_setup(ok);
                chk("wr_setup_seen", 64'(ok), 64'(1));
                m_paddr[15:8] = 8'hFF; m_pwdata[63:32] = 32'h0; m_pwrite[1] = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge pclk);
                    if (!penable_o) break;
                    accs++;
                    chk("wr_cmd_stable", {23'(0), pwrite_o, paddr_o, pwdata_o},
                        {23'(0), 1'b1, 8'h20, 32'h1234_5678});
                    if (m_pready_o[1] && rdy_at == 0) rdy_at = accs;
                end
                chk("wr_access_cycles", 64'(accs), 64'(4));
                chk("wr_ready_cycle", 64'(rdy_at), 64'(4));
            end
        join

        // Hung slave: abort with error on the 4th ACCESS cycle.
        wait_n = 0; slv_hang = 1'b1; prdata_i = 32'hCAFE_F00D;
        gnt_q.push_back(2'b01);
        rsp_q.push_back('{0, 1'b1, 32'h0});
        fork
            mxfer(0, 1'b0, 8'h30, 32'h0);
            begin
                accs = 0; rdy_at = 0;
                wait_setup(ok);
                for (int i = 0; i < 10; i++) begin
                    @(negedge pclk);
                    if (!penable_o) break;
                    accs++;
                    if (m_pready_o[0] && rdy_at == 0) rdy_at = accs;
                end
                chk("to_access_cycles", 64'(accs), 64'(4));
                chk("to_ready_cycle", 64'(rdy_at), 64'(4));
                chk("to_psel_after", 64'(psel_o), 64'(0));
            end
        join
        slv_hang = 1'b0;

        // Slave error passes through with read data.
        wait_n = 1; pslverr_i = 1'b1; prdata_i = 32'h0BAD_0BAD;
        gnt_q.push_back(2'b10);
        rsp_q.push_back('{1, 1'b1, 32'h0BAD_0BAD});
        mxfer(1, 1'b0, 8'h40, 32'h0);
        pslverr_i = 1'b0;

        // Master withdraws after SETUP: slave cycle runs, no response delivered.
        wait_n = 0; prdata_i = 32'h5555_AAAA;
        gnt_q.push_back(2'b01);
        m_psel[0] = 1'b1; m_paddr[7:0] = 8'h50; m_pwrite[0] = 1'b0;
        wait_setup(ok);
        chk("wd_setup_seen", 64'(ok), 64'(1));
        m_psel[0] = 1'b0;
        accs = 0; rdy_at = 0;
        repeat (4) begin
            @(negedge pclk);
            if (penable_o) accs++;
            if (m_pready_o != '0 || m_prdata_o != '0) rdy_at++;
        end
        chk("wd_slave_access", 64'(accs), 64'(1));
        chk("wd_no_response", 64'(rdy_at), 64'(0));
        @(posedge pclk);
        #1;

        // Asynchronous reset while m0 owns the port in ACCESS.
        slv_hang = 1'b1;
        gnt_q.push_back(2'b01);
        m_psel[0] = 1'b1; m_paddr[7:0] = 8'h60;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge pclk);
            ok = psel_o && penable_o;
        end
        chk("rst_access_seen", 64'(ok), 64'(1));
        #2 presetn = 1'b0;
        #1;
        chk("arst_ctrl", 64'({psel_o, penable_o, busy_o}), 64'(0));
        chk("arst_grant", 64'(grant_o), 64'(0));
        m_psel = '0; slv_hang = 1'b0;
        @(posedge pclk);
        #1 presetn = 1'b1;

        // After reset the pointer restarts, so m0 wins again.
        prdata_i = 32'h7777_0000;
        gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
        rsp_q.push_back('{0, 1'b0, 32'h7777_0000});
        rsp_q.push_back('{1, 1'b0, 32'h7777_0000});
        fork
            mxfer(0, 1'b0, 8'h70, 32'h0);
            mxfer(1, 1'b0, 8'h74, 32'h0);
        join

        repeat (3) @(posedge pclk);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        chk("gnt_q_drained", 64'(gnt_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
